genius_sequencer: RTL and testbench
===================================

// Module: genius_sequencer
// PURPOSE
//  Game-flow controller for the Genius (Simon) board design. Generates a pseudo-random colour
//  sequence from a switch seed, plays it on four LEDs, then collects and checks the player's
//  KEY presses. Drives round/score and win/lose status to the top-level HEX and LEDR decoders.
// PARAMETERS
//  TICKS_SHOW     25_000_000  LED-on cycles per step at level 0; actual = TICKS_SHOW >> level; must be >= 8
//  TICKS_GAP      12_500_000  LED-off cycles between playback steps
//  TICKS_TIMEOUT  250_000_000 max cycles waiting for each press before LOSE
//  MAX_ROUNDS     16          rounds needed to win; 1..31
// PORTS
//  clock     in   1   system clock (50 MHz)
//  reset     in   1   synchronous, active-high
//  enter_i   in   1   start/restart request (SW[0]); acts on rising edge only
//  btn_i     in   4   player keys, active-low (KEY[3:0]), already debounced
//  level_i   in   2   speed level (SW[9:8]); latched at game start
//  seed_i    in   4   sequence seed (SW[5:2]); latched at game start
//  led_o     out  4   one-hot colour display (registered)
//  round_o   out  5   current round, binary 1..MAX_ROUNDS; 0 in IDLE
//  score_o   out  5   rounds completed in current game
//  state_o   out  4   FSM state code (debug / HEX)
//  win_o     out  1   high while in WIN
//  lose_o    out  1   high while in LOSE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, edge-detect registers loaded with current inputs. Reset mid-game -> IDLE next cycle.
//  - LFSR: 8-bit Fibonacci, seed {seed_i,4'b1010} (never zero). fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0],fb}.
//    Step colour = l[1:0], then advance. Playback and input check both replay from seed; no sequence RAM.
//  - Enter rising edge = enter_i & ~enter_q. Honoured only in IDLE, WIN, LOSE; ignored otherwise.
//  - Press event = btn_i != 4'hF while btn_q == 4'hF (all keys previously released). Pressed value = index of the low bit.
//    More than one bit low at the event = wrong press.
//  - States:
//    IDLE     led 0; enter edge -> LOAD
//    LOAD     latch seed/level, round=1, score=0, win/lose=0 -> SHOW_ON (1 cycle)
//    SHOW_ON  led=onehot(l[1:0]) for TICKS_SHOW>>level cycles -> SHOW_OFF, advance LFSR, step++
//    SHOW_OFF led 0 for TICKS_GAP cycles; step<round -> SHOW_ON else reload seed, step=0 -> WAIT_IN
//    WAIT_IN  led = ~btn_i; press: match l[1:0] -> CHECK, mismatch -> LOSE; timer = TICKS_TIMEOUT -> LOSE
//    CHECK    advance LFSR, step++, timeout timer cleared; step<round -> WAIT_IN
//             else score++; round==MAX_ROUNDS -> WIN else round++, reload seed, step=0 -> SHOW_OFF (gap before replay)
//    WIN/LOSE led=4'hF (WIN) / 4'h0 (LOSE); hold round/score; enter edge -> LOAD
//  - Timing: enter edge sampled at edge k -> LOAD at k+1, SHOW_ON and first LED at k+2.
//  - Simultaneous press and timeout in same cycle: press wins.
//  - Counters: one shared 28-bit down/up timer, cleared on every state change; step counter 5 bits.
//  - level_i/seed_i changes mid-game have no effect until next LOAD.
// STRUCTURE
//  - genius_pkg: state encodings (IDLE=0,LOAD=1,SHOW_ON=2,SHOW_OFF=3,WAIT_IN=4,CHECK=5,WIN=6,LOSE=7),
//    LFSR taps, seed pad constant 4'b1010.
//  - Sub-module genius_lfsr (load, step, seed[7:0] -> value[1:0]); FSM, timer, edge detects in this module.
// TESTING (sim params: TICKS_SHOW=8, TICKS_GAP=4, TICKS_TIMEOUT=64, MAX_ROUNDS=4)
//  1 reset=1 3 cycles -> all outputs 0, state_o=0; enter held high across reset release -> no start.
//  2 seed_i=4'b0101, level_i=2'b01, enter rise -> round_o=1, led_o=4'b0100 for exactly 4 cycles, then 0 for 4.
//  3 Same game: btn_i=4'b1011 then release -> round_o=2, score_o=1; playback 4'b0100,4'b0001.
//  4 Full correct play, sequence 2,0,1,2 -> after round 4 win_o=1, led_o=4'hF, score_o=4; enter edge restarts.
//  5 Round 1, btn_i=4'b1110 (wrong) -> lose_o=1 next cycle, score_o=0; btn_i=4'b1010 (two keys) -> LOSE.
//  6 Round 1, no press for 64 cycles -> LOSE; reset asserted during SHOW_ON -> IDLE, led_o=0 next cycle.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius (Simon) game sequencer: state codes,
// LFSR feedback taps, seed padding and small helpers.
package genius_pkg;

    // State codes are exported on state_o, so the numeric values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_SHOW_ON  = 4'd2,
        ST_SHOW_OFF = 4'd3,
        ST_WAIT_IN  = 4'd4,
        ST_CHECK    = 4'd5,
        ST_WIN      = 4'd6,
        ST_LOSE     = 4'd7
    } state_t;

    // Low nibble of the LFSR seed; guarantees a non-zero start value.
    localparam logic [3:0] SEED_PAD  = 4'b1010;

    // Feedback taps l[7], l[5], l[4], l[3].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int TIMER_W = 28;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    function automatic logic lfsr_fb(input logic [7:0] l);
        return ^(l & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 8-bit Fibonacci LFSR producing one two-bit colour per step. The sequence
// is regenerated from the seed for every playback and every input check.
module genius_lfsr
    import genius_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [1:0] value
);

    logic [7:0] l;

    // Load has priority over step so a reload in the same cycle wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            l <= {4'b0000, SEED_PAD};
        end else if (load) begin
            l <= seed;
        end else if (step) begin
            l <= {l[6:0], lfsr_fb(l)};
        end
    end

    assign value = l[1:0];

endmodule

// File: rtl/genius_sequencer.sv
// Game-flow controller: plays a growing pseudo-random colour sequence on
// four LEDs, then checks the player's key presses against the same sequence.
module genius_sequencer
    import genius_pkg::*;
#(
    parameter int TICKS_SHOW    = 25_000_000,
    parameter int TICKS_GAP     = 12_500_000,
    parameter int TICKS_TIMEOUT = 250_000_000,
    parameter int MAX_ROUNDS    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter_i,
    input  logic [3:0] btn_i,
    input  logic [1:0] level_i,
    input  logic [3:0] seed_i,
    output logic [3:0] led_o,
    output logic [4:0] round_o,
    output logic [4:0] score_o,
    output logic [3:0] state_o,
    output logic       win_o,
    output logic       lose_o
);

    localparam logic [TIMER_W-1:0] SHOW_BASE    = 28'(TICKS_SHOW);
    localparam logic [TIMER_W-1:0] GAP_LAST     = 28'(TICKS_GAP - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = 28'(TICKS_TIMEOUT - 1);
    localparam logic [4:0]         ROUND_MAX    = 5'(MAX_ROUNDS);

    state_t               state;
    logic                 enter_q;
    logic [3:0]           btn_q;
    logic [3:0]           seed_q;
    logic [1:0]           level_q;
    logic [TIMER_W-1:0]   timer;
    logic [4:0]           step;

    logic [1:0]           colour;
    logic [TIMER_W-1:0]   show_last;
    logic [4:0]           step_next;
    logic                 start;
    logic                 press_evt;
    logic                 press_single;
    logic [1:0]           press_key;
    logic                 press_ok;
    logic                 show_done;
    logic                 gap_done;
    logic                 timed_out;
    logic                 lfsr_load;
    logic                 lfsr_step;
    logic [7:0]           lfsr_seed;

    genius_lfsr u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (lfsr_seed),
        .value (colour)
    );

    // Event detection and LFSR control derived from the current state.
    always_comb begin
        start        = enter_i && !enter_q &&
                       (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
        press_evt    = (btn_i != 4'hF) && (btn_q == 4'hF);
        press_single = 1'b0;
        press_key    = 2'd0;
        case (btn_i)
            4'b1110: begin press_single = 1'b1; press_key = 2'd0; end
            4'b1101: begin press_single = 1'b1; press_key = 2'd1; end
            4'b1011: begin press_single = 1'b1; press_key = 2'd2; end
            4'b0111: begin press_single = 1'b1; press_key = 2'd3; end
            default: ;
        endcase
        press_ok  = press_single && (press_key == colour);
        step_next = step + 5'd1;
        show_last = (SHOW_BASE >> level_q) - 28'd1;
        show_done = (timer == show_last);
        gap_done  = (timer == GAP_LAST);
        timed_out = (timer == TIMEOUT_LAST);

        lfsr_load = start ||
                    (state == ST_SHOW_OFF && gap_done && !(step < round_o)) ||
                    (state == ST_CHECK && !(step_next < round_o) && round_o != ROUND_MAX);
        lfsr_step = (state == ST_SHOW_ON && show_done) || (state == ST_CHECK);
        lfsr_seed = start ? {seed_i, SEED_PAD} : {seed_q, SEED_PAD};
    end

    // Game FSM with its shared timer, step counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            enter_q <= enter_i;
            btn_q   <= btn_i;
            seed_q  <= 4'd0;
            level_q <= 2'd0;
            timer   <= '0;
            step    <= 5'd0;
            led_o   <= 4'd0;
            round_o <= 5'd0;
            score_o <= 5'd0;
            win_o   <= 1'b0;
            lose_o  <= 1'b0;
        end else begin
            enter_q <= enter_i;
            btn_q   <= btn_i;
            timer   <= '0;
            case (state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    led_o <= (state == ST_WIN) ? 4'hF : 4'h0;
                    if (start) begin
                        seed_q  <= seed_i;
                        level_q <= level_i;
                        win_o   <= 1'b0;
                        lose_o  <= 1'b0;
                        led_o   <= 4'h0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    round_o <= 5'd1;
                    score_o <= 5'd0;
                    step    <= 5'd0;
                    led_o   <= onehot4(colour);
                    state   <= ST_SHOW_ON;
                end
                ST_SHOW_ON: begin
                    timer <= timer + 28'd1;
                    if (show_done) begin
                        timer <= '0;
                        led_o <= 4'h0;
                        step  <= step_next;
                        state <= ST_SHOW_OFF;
                    end
                end
                ST_SHOW_OFF: begin
                    timer <= timer + 28'd1;
                    if (gap_done) begin
                        timer <= '0;
                        if (step < round_o) begin
                            led_o <= onehot4(colour);
                            state <= ST_SHOW_ON;
                        end else begin
                            step  <= 5'd0;
                            led_o <= ~btn_i;
                            state <= ST_WAIT_IN;
                        end
                    end
                end
                ST_WAIT_IN: begin
                    timer <= timer + 28'd1;
                    led_o <= ~btn_i;
                    // A press in the same cycle as the timeout takes precedence.
                    if (press_evt) begin
                        timer <= '0;
                        if (press_ok) begin
                            state <= ST_CHECK;
                        end else begin
                            led_o  <= 4'h0;
                            lose_o <= 1'b1;
                            state  <= ST_LOSE;
                        end
                    end else if (timed_out) begin
                        timer  <= '0;
                        led_o  <= 4'h0;
                        lose_o <= 1'b1;
                        state  <= ST_LOSE;
                    end
                end
                ST_CHECK: begin
                    step  <= step_next;
                    led_o <= ~btn_i;
                    if (step_next < round_o) begin
                        state <= ST_WAIT_IN;
                    end else begin
                        score_o <= score_o + 5'd1;
                        if (round_o == ROUND_MAX) begin
                            led_o <= 4'hF;
                            win_o <= 1'b1;
                            state <= ST_WIN;
                        end else begin
                            round_o <= round_o + 5'd1;
                            step    <= 5'd0;
                            led_o   <= 4'h0;
                            state   <= ST_SHOW_OFF;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_genius_sequencer.sv
// Bench for genius_sequencer with small timing parameters.
module tb_genius_sequencer;

  localparam int SHOW       = 8;
  localparam int GAP        = 4;
  localparam int TIMEOUT    = 64;
  localparam int MAX_ROUNDS = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter_i = 1'b0;
  logic [3:0] btn_i = 4'hF;
  logic [1:0] level_i = 2'd0;
  logic [3:0] seed_i = 4'd0;
  logic [3:0] led_o;
  logic [4:0] round_o;
  logic [4:0] score_o;
  logic [3:0] state_o;
  logic       win_o;
  logic       lose_o;

  int tests = 0;
  int fails = 0;

  logic [1:0] seq [0:MAX_ROUNDS-1];

  genius_sequencer #(
    .TICKS_SHOW    (SHOW),
    .TICKS_GAP     (GAP),
    .TICKS_TIMEOUT (TIMEOUT),
    .MAX_ROUNDS    (MAX_ROUNDS)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enter_i (enter_i),
    .btn_i   (btn_i),
    .level_i (level_i),
    .seed_i  (seed_i),
    .led_o   (led_o),
    .round_o (round_o),
    .score_o (score_o),
    .state_o (state_o),
    .win_o   (win_o),
    .lose_o  (lose_o)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Colour number idx of the game started with this seed, from the LFSR rule.
  function automatic logic [1:0] colour_of(input logic [3:0] seed, input int idx);
    logic [7:0] l;
    l = {seed, 4'b1010};
    for (int i = 0; i < idx; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l[1:0];
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget, input string name);
    int n = 0;
    while (state_o !== target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(state_o), 32'(target));
  endtask

  // Leaves the bench on the first SHOW_ON cycle.
  task automatic start_game(input logic [3:0] seed, input logic [1:0] level);
    enter_i = 1'b0;
    seed_i  = seed;
    level_i = level;
    tick();
    enter_i = 1'b1;
    tick();
    check("start_load_state", 32'(state_o), 1);
    check("start_flags", 32'({win_o, lose_o}), 0);
    tick();
    check("start_show_state", 32'(state_o), 2);
    check("start_round", 32'(round_o), 1);
    check("start_score", 32'(score_o), 0);
    enter_i = 1'b0;
  endtask

  // Plays a whole game against seq[]; fail_kind 0 none, 1 wrong key, 2 two keys, 3 timeout.
  task automatic play_game(input logic [3:0] seed, input logic [1:0] level,
                           input int fail_round, input int fail_step,
                           input int fail_kind, input int max_delay);
    int show_len;
    int dly;
    logic [3:0] bad;
    show_len = SHOW >> level;
    start_game(seed, level);
    seed_i  = 4'($urandom);
    level_i = 2'($urandom);
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      if (r > 1) begin
        for (int c = 0; c < GAP; c++) begin
          check("pre_gap_led", 32'(led_o), 0);
          tick();
        end
      end
      for (int s = 0; s < r; s++) begin
        for (int c = 0; c < show_len; c++) begin
          check("show_led", 32'(led_o), 32'(oh(seq[s])));
          tick();
        end
        for (int c = 0; c < GAP; c++) begin
          check("gap_led", 32'(led_o), 0);
          tick();
        end
      end
      check("wait_state", 32'(state_o), 4);
      check("wait_round", 32'(round_o), r);
      for (int s = 0; s < r; s++) begin
        if (r == fail_round && s == fail_step) begin
          if (fail_kind == 3) begin
            repeat (TIMEOUT - 1) tick();
            check("timeout_not_yet", 32'(lose_o), 0);
            tick();
          end else begin
            dly = $urandom_range(0, max_delay);
            repeat (dly) tick();
            if (fail_kind == 1) bad = ~oh(seq[s] + 2'd1);
            else bad = ~(oh(seq[s]) | oh(seq[s] + 2'($urandom_range(1, 3))));
            btn_i = bad;
            tick();
          end
          check("lose_flag", 32'(lose_o), 1);
          check("lose_state", 32'(state_o), 7);
          check("lose_led", 32'(led_o), 0);
          check("lose_score", 32'(score_o), r - 1);
          check("lose_round", 32'(round_o), r);
          btn_i = 4'hF;
          repeat (3) tick();
          check("lose_hold", 32'({lose_o, win_o, state_o}), 32'h27);
          return;
        end
        dly = $urandom_range(0, max_delay);
        repeat (dly) tick();
        btn_i = ~oh(seq[s]);
        tick();
        check("check_state", 32'(state_o), 5);
        check("press_led", 32'(led_o), 32'(oh(seq[s])));
        btn_i = 4'hF;
        tick();
      end
      check("round_score", 32'(score_o), r);
      if (r < MAX_ROUNDS) begin
        check("next_round", 32'(round_o), r + 1);
        check("next_state", 32'(state_o), 3);
      end else begin
        check("win_flag", 32'(win_o), 1);
        check("win_led", 32'(led_o), 32'hF);
        check("win_state", 32'(state_o), 6);
        check("win_round", 32'(round_o), MAX_ROUNDS);
      end
    end
    repeat (3) tick();
    check("win_hold", 32'({win_o, lose_o, led_o}), 32'h2F);
  endtask

  typedef struct {
    logic [1:0] level;
    logic [3:0] btn;
    int         exp_on;
    logic [3:0] exp_state;
    logic       exp_lose;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [3:0] sd;
    int cnt;
    int kind;
    int fr;
    int fs;

    vecs[0] = '{2'd0, 4'b1011, 8, 4'd5, 1'b0};
    vecs[1] = '{2'd1, 4'b1110, 4, 4'd7, 1'b1};
    vecs[2] = '{2'd2, 4'b1101, 2, 4'd7, 1'b1};
    vecs[3] = '{2'd3, 4'b0111, 1, 4'd7, 1'b1};
    vecs[4] = '{2'd1, 4'b1010, 4, 4'd7, 1'b1};
    vecs[5] = '{2'd0, 4'b0000, 8, 4'd7, 1'b1};
    vecs[6] = '{2'd2, 4'b1011, 2, 4'd5, 1'b0};

    // Reset values, and enter held high across reset release must not start.
    enter_i = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_led", 32'(led_o), 0);
    check("rst_round", 32'(round_o), 0);
    check("rst_score", 32'(score_o), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_win", 32'(win_o), 0);
    check("rst_lose", 32'(lose_o), 0);
    reset = 1'b0;
    repeat (3) tick();
    check("held_enter_no_start", 32'(state_o), 0);
    enter_i = 1'b0;
    tick();

    // Speed level and press classification table.
    foreach (vecs[i]) begin
      do_reset();
      sd = 4'($urandom);
      start_game(sd, vecs[i].level);
      cnt = 0;
      while (led_o == oh(colour_of(sd, 0)) && cnt < 20) begin
        cnt++;
        tick();
      end
      check("level_on_cycles", 32'(cnt), 32'(vecs[i].exp_on));
      wait_state(4'd4, 20, "vec_reach_wait");
      btn_i = vecs[i].btn;
      tick();
      check("vec_next_state", 32'(state_o), 32'(vecs[i].exp_state));
      check("vec_lose", 32'(lose_o), 32'(vecs[i].exp_lose));
      btn_i = 4'hF;
      tick();
    end

    // Enter edge while waiting for input is ignored.
    do_reset();
    start_game(4'h3, 2'd2);
    wait_state(4'd4, 20, "ign_reach_wait");
    enter_i = 1'b1;
    tick();
    enter_i = 1'b0;
    tick();
    check("enter_ignored", 32'(state_o), 4);

    // Known sequence 2,0,1,2 for seed 0101, full win, then restart.
    do_reset();
    seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd1; seq[3] = 2'd2;
    play_game(4'b0101, 2'd1, 0, 0, 0, 3);
    start_game(4'b0101, 2'd1);
    check("restart_led", 32'(led_o), 32'h4);

    // Reset in the middle of SHOW_ON returns to IDLE with LEDs off.
    tick();
    reset = 1'b1;
    tick();
    check("midgame_rst_led", 32'(led_o), 0);
    check("midgame_rst_state", 32'(state_o), 0);
    check("midgame_rst_round", 32'(round_o), 0);
    reset = 1'b0;
    tick();

    // Directed losses in round 1: wrong key, two keys, timeout.
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < MAX_ROUNDS; i++) seq[i] = colour_of(4'hA, i);
      play_game(4'hA, 2'd1, 1, 0, k, 2);
    end

    // Randomised games against the sequence model.
    for (int g = 0; g < 24; g++) begin
      sd   = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      fr   = (kind == 0) ? 0 : $urandom_range(1, MAX_ROUNDS);
      fs   = (kind == 0) ? 0 : $urandom_range(0, fr - 1);
      for (int i = 0; i < MAX_ROUNDS; i++) seq[i] = colour_of(sd, i);
      play_game(sd, 2'($urandom_range(0, 3)), fr, fs, kind, 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
